// File: rtl/button_ui_pkg.sv
// Shared definitions for the button UI blocks.
// Holds the button code map, the event type encoding, the event encoder
// FSM state type and small helpers that turn the nine resolved button
// levels into a code, classify arrow keys and look up the latched level.
package button_ui_pkg;

    // Button codes carried on event_code
    localparam logic [3:0] BTN_0     = 4'd0;
    localparam logic [3:0] BTN_1     = 4'd1;
    localparam logic [3:0] BTN_2     = 4'd2;
    localparam logic [3:0] BTN_3     = 4'd3;
    localparam logic [3:0] BTN_ENTER = 4'd4;
    localparam logic [3:0] BTN_LEFT  = 4'd5;
    localparam logic [3:0] BTN_RIGHT = 4'd6;
    localparam logic [3:0] BTN_UP    = 4'd7;
    localparam logic [3:0] BTN_DOWN  = 4'd8;
    localparam logic [3:0] BTN_NONE  = 4'hF;

    localparam int NUM_BUTTONS = 9;

    // Event types carried on event_type
    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_REPEAT  = 2'd1;
    localparam logic [1:0] EV_LONG    = 2'd2;
    localparam logic [1:0] EV_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_REPEATING,
        ST_HELD
    } state_e;

    // Returns the code of the single high bit, or BTN_NONE when zero or
    // several bits are high (a multi-hot vector must never start a press).
    function automatic logic [3:0] encodeButtons(input logic [NUM_BUTTONS-1:0] levels);
        logic [3:0] code;
        int         highCount;
        code      = BTN_NONE;
        highCount = 0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (levels[i]) begin
                highCount = highCount + 1;
                code      = 4'(i);
            end
        end
        if (highCount != 1) begin
            code = BTN_NONE;
        end
        return code;
    endfunction

    function automatic logic isArrow(input logic [3:0] code);
        return (code >= BTN_LEFT) && (code <= BTN_DOWN);
    endfunction

    // Level of the button selected by code; BTN_NONE reads as released.
    function automatic logic levelOf(input logic [NUM_BUTTONS-1:0] levels,
                                     input logic [3:0]             code);
        logic level;
        level = 1'b0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (code == 4'(i)) begin
                level = levels[i];
            end
        end
        return level;
    endfunction

endpackage

// File: rtl/button_event_slot.sv
// One-entry output register for button events.
// A new event is loaded when the slot is empty or is being emptied by a
// handshake in the same cycle; otherwise the event is lost and the sticky
// overflow flag is raised until reset.
//   clk_i, reset_i      clock, synchronous active-high reset
//   load_i              an event is emitted this cycle
//   code_i, type_i      code and type of the emitted event
//   ready_i             consumer accepts the pending event
//   valid_o             event pending
//   code_o, type_o      pending event contents
//   overflow_o          sticky: an event was dropped
module button_event_slot
    import button_ui_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [3:0] code_i,
    input  logic [1:0] type_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [3:0] code_o,
    output logic [1:0] type_o,
    output logic       overflow_o
);

    logic       valid_q,    valid_d;
    logic [3:0] code_q,     code_d;
    logic [1:0] type_q,     type_d;
    logic       overflow_q, overflow_d;

    // Slot update: load wins over a plain handshake so back-to-back events
    // flow every cycle while the consumer is ready.
    always_comb begin
        valid_d    = valid_q;
        code_d     = code_q;
        type_d     = type_q;
        overflow_d = overflow_q;
        if (load_i) begin
            if (!valid_q || ready_i) begin
                valid_d = 1'b1;
                code_d  = code_i;
                type_d  = type_i;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q    <= 1'b0;
            code_q     <= BTN_NONE;
            type_q     <= EV_PRESS;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            code_q     <= code_d;
            type_q     <= type_d;
            overflow_q <= overflow_d;
        end
    end

    assign valid_o    = valid_q;
    assign code_o     = code_q;
    assign type_o     = type_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/button_event_encoder.sv
// Turns resolved one-hot button levels into PRESS / LONG / REPEAT / RELEASE
// events with a 4-bit button code, delivered through a valid/ready slot.
// Arrow keys auto-repeat while held; other buttons emit one LONG event.
//   clk, reset                    clock, synchronous active-high reset
//   button*_in                    resolved button levels, at most one high
//   event_valid / event_ready     output handshake
//   event_code, event_type        pending event contents
//   overflow                      sticky: an event was dropped
module button_event_encoder
    import button_ui_pkg::*;
#(
    parameter int HOLD_DELAY    = 16200000,
    parameter int REPEAT_PERIOD = 4050000,
    parameter int CNT_W         = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button0_in,
    input  logic       button1_in,
    input  logic       button2_in,
    input  logic       button3_in,
    input  logic       button_enter_in,
    input  logic       button_left_in,
    input  logic       button_right_in,
    input  logic       button_up_in,
    input  logic       button_down_in,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [3:0] event_code,
    output logic [1:0] event_type,
    output logic       overflow
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [NUM_BUTTONS-1:0] buttons;
    logic [3:0]             pressCode;
    logic                   latchedLevel;

    state_e                 state_q,   state_d;
    logic [CNT_W-1:0]       count_q,   count_d;
    logic [3:0]             latched_q, latched_d;

    logic                   emit;
    logic [3:0]             emitCode;
    logic [1:0]             emitType;

    // Bit index equals the button code, so encoding is just the bit position.
    assign buttons = {button_down_in, button_up_in, button_right_in, button_left_in,
                      button_enter_in, button3_in, button2_in, button1_in, button0_in};

    assign pressCode    = encodeButtons(buttons);
    // Only the latched bit decides release; other bits are ignored until IDLE.
    assign latchedLevel = levelOf(buttons, latched_q);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        latched_d = latched_q;
        emit      = 1'b0;
        emitCode  = latched_q;
        emitType  = EV_PRESS;
        unique case (state_q)
            ST_IDLE: begin
                if (pressCode != BTN_NONE) begin
                    latched_d = pressCode;
                    emit      = 1'b1;
                    emitCode  = pressCode;
                    emitType  = EV_PRESS;
                    count_d   = '0;
                    state_d   = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (!latchedLevel) begin
                    emit      = 1'b1;
                    emitType  = EV_RELEASE;
                    latched_d = BTN_NONE;
                    state_d   = ST_IDLE;
                end else if (count_q == HOLD_LAST) begin
                    emit = 1'b1;
                    if (isArrow(latched_q)) begin
                        emitType = EV_REPEAT;
                        count_d  = '0;
                        state_d  = ST_REPEATING;
                    end else begin
                        emitType = EV_LONG;
                        state_d  = ST_HELD;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_REPEATING: begin
                if (!latchedLevel) begin
                    emit      = 1'b1;
                    emitType  = EV_RELEASE;
                    latched_d = BTN_NONE;
                    state_d   = ST_IDLE;
                end else if (count_q == REPEAT_LAST) begin
                    emit     = 1'b1;
                    emitType = EV_REPEAT;
                    count_d  = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!latchedLevel) begin
                    emit      = 1'b1;
                    emitType  = EV_RELEASE;
                    latched_d = BTN_NONE;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            latched_q <= BTN_NONE;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            latched_q <= latched_d;
        end
    end

    button_event_slot u_slot (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (emit),
        .code_i     (emitCode),
        .type_i     (emitType),
        .ready_i    (event_ready),
        .valid_o    (event_valid),
        .code_o     (event_code),
        .type_o     (event_type),
        .overflow_o (overflow)
    );

endmodule

// File: doc/button_event_encoder.md
# button_event_encoder

Converts the one-hot, contention-free button levels from the button contention resolver into discrete UI events (press, long-press, auto-repeat, release) with a 4-bit button code. Sits between the button interface and the UI menu/dial FSMs, so those consumers see one-cycle-qualified events through a valid/ready handshake and never track press duration themselves. Arrow keys auto-repeat while held; the other buttons emit a single long-press event.

## Interface
- HOLD_DELAY, 16200000, cycles a button must be held before the first LONG/REPEAT event (600 ms at 27 MHz)
- REPEAT_PERIOD, 4050000, cycles between successive REPEAT events (150 ms at 27 MHz)
- CNT_W, 25, hold counter width; must satisfy 2^CNT_W > max(HOLD_DELAY, REPEAT_PERIOD)
- One clock; reset is synchronous and active-high.
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- button0_in, button1_in, button2_in, button3_in, button_enter_in, button_left_in, button_right_in, button_up_in, button_down_in  in  1 each  resolved button levels, at most one high
- event_valid  out  1  event pending
- event_ready  in  1  consumer accepts the event on a cycle where event_valid & event_ready
- event_code  out  4  0–3 = button0–3, 4 = enter, 5 = left, 6 = right, 7 = up, 8 = down, 15 = none
- event_type  out  2  0 PRESS, 1 REPEAT, 2 LONG, 3 RELEASE
- overflow  out  1  sticky: an event was dropped

## Operation
- Reset: event_valid = 0, event_code = 4'hF, event_type = 0, overflow = 0, state = IDLE, counter = 0, latched code = 4'hF.
- IDLE:
  - Exactly one input high: latch its code, emit PRESS, clear counter, go to PRESSED.
  - Zero inputs or more than one input high: no action. No event is emitted for an illegal multi-hot input.
- PRESSED:
  - Latched button low: emit RELEASE, go to IDLE.
  - Otherwise, when counter == HOLD_DELAY-1:
    - Arrow key (code 5–8): emit REPEAT, clear counter, go to REPEATING.
    - Any other button: emit LONG, go to HELD.
  - Otherwise increment the counter.
- REPEATING:
  - Latched button low: emit RELEASE, go to IDLE.
  - When counter == REPEAT_PERIOD-1: emit REPEAT and clear the counter.
  - Otherwise increment the counter.
- HELD: latched button low emits RELEASE and returns to IDLE. The counter is frozen.
- Release is detected only on the latched bit. If a different bit goes high while the latched bit drops, this is treated as a RELEASE; the new bit is then ignored until it is seen in IDLE.
- Event output slot:
  - An emitted event loads code and type when !event_valid or event_ready; otherwise the event is dropped and overflow is set.
  - event_valid clears on a handshake with no simultaneous load.
  - overflow is cleared only by reset.

## Timing
- Inputs are sampled at each posedge.
- An input first seen high at edge N produces PRESS visible after edge N, with event_valid high in cycle N+1.
- The first LONG/REPEAT loads at edge N+HOLD_DELAY.
- Later REPEATs load every REPEAT_PERIOD edges.
- RELEASE loads at the first edge that samples the latched bit low.
- Back-to-back events are accepted every cycle while event_ready = 1.
- Reset mid-operation aborts with no RELEASE emitted. A button still held after reset is treated as a new PRESS.

## Structure
- Shared package button_ui_pkg holds:
  - button code constants (BTN_0 … BTN_DOWN, BTN_NONE = 4'hF)
  - event type constants (EV_PRESS, EV_REPEAT, EV_LONG, EV_RELEASE)
  - FSM state encoding
- One sub-module, button_event_slot, holds the 1-entry valid/ready output register and the overflow flag. The FSM, counter, and priority encoder stay in the top module.

## Test plan
Tests use HOLD_DELAY = 8 and REPEAT_PERIOD = 3.
- button2_in high for 5 cycles with event_ready = 1 -> PRESS/2, then RELEASE/2 one cycle after the drop; no LONG event.
- button_enter_in held for 20 cycles -> PRESS/4, LONG/4 exactly 8 cycles after PRESS, RELEASE/4 after the drop; no REPEAT event.
- button_up_in held for 16 cycles -> PRESS/7 at t0, REPEAT/7 at t8, t11, t14, then RELEASE/7.
- event_ready = 0, press and release button0 -> PRESS/0 stays held and RELEASE is dropped with overflow = 1; raising event_ready clears event_valid on the next cycle.
- Reset asserted while button_left is repeating, with the button still held -> all outputs at reset values; the first cycle after reset yields PRESS/5.
- button1_in and button3_in high together in IDLE -> no event and state stays IDLE; button1_in alone afterwards -> PRESS/1.
